// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared state encoding and constants for the coffee machine blocks
package coffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_ON   = 3'd2,
        ST_OFF  = 3'd3,
        ST_DONE = 3'd4
    } disp_state_t;

    localparam int COIN_UNIT = 100;
    localparam int TICK_HZ   = 1000;

endpackage

// File: rtl/ms_timer.sv
// rtl/ms_timer.sv - counts tick strobes and pulses expire on the tick that reaches load
module ms_timer
    import coffee_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             clear,
    input  logic [WIDTH-1:0] load,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= count + 1'b1;
        end
    end

    // Combinational so the owner can clear and change phase on the same edge.
    assign expire = tick && (({1'b0, count} + (WIDTH + 1)'(1)) == {1'b0, load});

endmodule

// File: rtl/coin_dispenser.sv
// rtl/coin_dispenser.sv - converts a won balance into paced 100-won coin pulses
module coin_dispenser
    import coffee_pkg::*;
#(
    parameter int MAX_COINS = 99,
    parameter int ON_MS     = 200,
    parameter int OFF_MS    = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start,
    input  logic [15:0] amount,
    output logic        busy,
    output logic        done,
    output logic        coin_led,
    output logic        coin_strobe,
    output logic [7:0]  coins_left,
    output logic        err
);

    disp_state_t state;
    logic [15:0] rem;
    logic [15:0] timer_load;
    logic        timer_clear;
    logic        timer_expire;

    assign timer_load  = (state == ST_OFF) ? 16'(OFF_MS) : 16'(ON_MS);
    // Held clear outside the paced phases and on each phase change so every window starts at zero.
    assign timer_clear = timer_expire || !((state == ST_ON) || (state == ST_OFF));

    ms_timer #(
        .WIDTH(16)
    ) u_ms_timer (
        .clk   (clk),
        .resetn(reset),
        .tick  (tick),
        .clear (timer_clear),
        .load  (timer_load),
        .expire(timer_expire)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            coin_led    <= 1'b0;
            coin_strobe <= 1'b0;
            coins_left  <= '0;
            err         <= 1'b0;
        end else begin
            coin_strobe <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rem        <= amount;
                        coins_left <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (rem >= 16'(COIN_UNIT)) begin
                        // An oversized request dispenses nothing at all.
                        if (coins_left >= 8'(MAX_COINS)) begin
                            err        <= 1'b1;
                            coins_left <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            rem        <= rem - 16'(COIN_UNIT);
                            coins_left <= coins_left + 8'd1;
                        end
                    end else begin
                        if (rem != '0) begin
                            err <= 1'b1;
                        end
                        if (coins_left == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            coin_led    <= 1'b1;
                            coin_strobe <= 1'b1;
                            state       <= ST_ON;
                        end
                    end
                end
                ST_ON: begin
                    if (timer_expire) begin
                        coins_left <= coins_left - 8'd1;
                        coin_led   <= 1'b0;
                        state      <= ST_OFF;
                    end
                end
                ST_OFF: begin
                    if (timer_expire) begin
                        if (coins_left == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            coin_led    <= 1'b1;
                            coin_strobe <= 1'b1;
                            state       <= ST_ON;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_dispenser.sv
// tb/tb_coin_dispenser.sv - self-checking bench for coin_dispenser with a request-level model
module tb_coin_dispenser;
    import coffee_pkg::*;

    localparam int ON_MS     = 2;
    localparam int OFF_MS    = 3;
    localparam int MAX_COINS = 99;
    localparam int TICK_DIV  = 8;
    localparam int BUDGET    = 6000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [15:0] amount = '0;
    logic        busy;
    logic        done;
    logic        coin_led;
    logic        coin_strobe;
    logic [7:0]  coins_left;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    coin_dispenser #(
        .MAX_COINS(MAX_COINS),
        .ON_MS    (ON_MS),
        .OFF_MS   (OFF_MS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .amount     (amount),
        .busy       (busy),
        .done       (done),
        .coin_led   (coin_led),
        .coin_strobe(coin_strobe),
        .coins_left (coins_left),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % TICK_DIV;
            tick = (ph == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_led"}, coin_led, 0);
        chk({tag, "_strobe"}, coin_strobe, 0);
        chk({tag, "_coins"}, coins_left, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // glitch_coin: re-assert start during that coin's ON window; reset_coin: pull reset there.
    task automatic run_req(input logic [15:0] a, input int glitch_coin, input int reset_coin);
        int  exp_n, strobes, rises, led_ticks, off_ticks, done_cnt, done_cyc, busy_cyc, cyc, bad_done;
        bit  ovf, exp_err, aborted, glitched, glitch_pending;
        logic prev_led;
        ovf     = (int'(a) / COIN_UNIT) > MAX_COINS;
        exp_n   = ovf ? 0 : int'(a) / COIN_UNIT;
        exp_err = ovf || ((int'(a) % COIN_UNIT) != 0);
        strobes = 0; rises = 0; led_ticks = 0; off_ticks = 0; done_cnt = 0;
        done_cyc = 0; busy_cyc = 0; cyc = 0; bad_done = 0;
        aborted = 0; glitched = 0; glitch_pending = 0; prev_led = 1'b0;

        step();
        start  = 1'b1;
        amount = a;
        step();
        start  = 1'b0;
        amount = 16'($urandom);

        while (cyc < BUDGET && done_cnt == 0 && !aborted) begin
            @(negedge clk);
            cyc++;
            if (glitch_pending) begin
                start = 1'b0;
                glitch_pending = 0;
            end
            if (cyc == 1) begin
                chk("busy_after_start", busy, 1);
                chk("err_cleared_on_start", err, 0);
            end
            if (busy) busy_cyc++;
            if (coin_strobe) begin
                strobes++;
                chk("strobe_with_led", coin_led, 1);
                chk("coins_left_at_strobe", coins_left, exp_n - strobes + 1);
                if (strobes == 1) chk("first_strobe_cycle", cyc, exp_n + 2);
            end
            if (coin_led && !prev_led) rises++;
            if (tick && coin_led) led_ticks++;
            if (tick && busy && !coin_led && strobes > 0) off_ticks++;
            prev_led = coin_led;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_with_done", busy, 0);
            end
            if (glitch_coin != 0 && strobes == glitch_coin && coin_led && !glitched) begin
                glitched = 1;
                glitch_pending = 1;
                start  = 1'b1;
                amount = 16'd300;
            end
            if (reset_coin != 0 && strobes == reset_coin && coin_led) begin
                reset   = 1'b0;
                aborted = 1;
            end
        end

        if (aborted) begin
            @(negedge clk);
            check_all_zero("reset_mid_dispense");
            reset = 1'b1;
            repeat (60) begin
                @(negedge clk);
                if (done || busy || coin_led) bad_done++;
            end
            chk("quiet_after_reset", bad_done, 0);
            return;
        end

        chk("done_seen_once", done_cnt, 1);
        chk("coin_count", strobes, exp_n);
        chk("led_pulses", rises, exp_n);
        chk("led_on_ticks", led_ticks, exp_n * ON_MS);
        chk("led_off_ticks", off_ticks, exp_n * OFF_MS);
        chk("err_at_done", err, exp_err);
        chk("coins_left_at_done", coins_left, 0);
        if (exp_n == 0 && !ovf) begin
            chk("zero_done_cycle", done_cyc, 2);
            chk("zero_busy_cycles", busy_cyc, 1);
        end
        if (ovf) chk("overflow_done_cycle", done_cyc, MAX_COINS + 2);

        repeat (3) begin
            @(negedge clk);
            if (done) bad_done++;
            if (busy || coin_led) bad_done++;
        end
        chk("post_done_quiet", bad_done, 0);
        chk("err_held_after_done", err, exp_err);
    endtask

    initial begin
        int changed;
        logic [15:0] ra;

        reset = 1'b0;
        repeat (5) step();
        @(negedge clk);
        check_all_zero("in_reset");
        step();
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        changed = 0;
        repeat (10 * TICK_DIV) begin
            @(negedge clk);
            if (busy || done || coin_led || coin_strobe || coins_left != 0 || err) changed++;
        end
        chk("idle_ticks_ignored", changed, 0);

        run_req(16'd300, 0, 0);
        run_req(16'd250, 0, 0);
        run_req(16'd100, 0, 0);
        run_req(16'd0, 0, 0);
        run_req(16'd10000, 0, 0);
        run_req(16'd500, 2, 0);
        run_req(16'd500, 0, 3);
        run_req(16'd300, 0, 0);
        run_req(16'd99, 0, 0);
        run_req(16'd9900, 0, 0);

        repeat (8) begin
            ra = 16'($urandom_range(0, 1300));
            run_req(ra, 0, 0);
        end
        ra = 16'($urandom_range(10000, 65535));
        run_req(ra, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
